// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, 2-of-3 mid-bit vote, LSB-first deserialise, parity/stop check.
// Result pulses land on the vote-point edge of the stop bit; no backpressure, one word delivered per frame.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [3:0]            edge_count,
    input  logic [4:0]            bit_count,
    output logic                  edge_bit_enable,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int M = PRESCALE / 2;
    localparam logic [3:0] EDGE_S0   = 4'(M - 1);
    localparam logic [3:0] EDGE_S1   = 4'(M);
    localparam logic [3:0] EDGE_S2   = 4'(M + 1);
    localparam logic [3:0] EDGE_VOTE = 4'(M + 2);

    localparam logic [4:0] BIT_START      = 5'd0;
    localparam logic [4:0] BIT_FIRST_DATA = 5'd1;
    localparam logic [4:0] BIT_AFTER_DATA = 5'(DATA_WIDTH + 1);
    localparam logic [4:0] BIT_AFTER_PAR  = 5'(DATA_WIDTH + 2);

    logic [2:0]            state_q,   state_d;
    logic                  en_q,      en_d;
    logic [DATA_WIDTH-1:0] p_data_q,  p_data_d;
    logic                  dv_q,      dv_d;
    logic                  perr_q,    perr_d;
    logic                  serr_q,    serr_d;
    logic                  busy_q,    busy_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [2:0]            smp_q,     smp_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_mis_q, par_mis_d;

    logic       vote;
    logic       vote_pt;
    logic [4:0] last_idx;

    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign vote_pt  = (edge_count == EDGE_VOTE);
    assign last_idx = par_en_q ? BIT_AFTER_PAR : BIT_AFTER_DATA;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        shift_d   = shift_q;
        smp_d     = smp_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_mis_d = par_mis_q;

        if (state_q != S_IDLE) begin
            if (edge_count == EDGE_S0) smp_d[0] = RX_IN;
            if (edge_count == EDGE_S1) smp_d[1] = RX_IN;
            if (edge_count == EDGE_S2) smp_d[2] = RX_IN;
        end

        case (state_q)
            S_IDLE: begin
                if (!RX_IN) begin
                    state_d   = S_START;
                    en_d      = 1'b1;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_mis_d = 1'b0;
                    shift_d   = '0;
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch: abandon silently.
                if (vote_pt && bit_count == BIT_START && vote) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                end else if (bit_count == BIT_FIRST_DATA) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (vote_pt) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_count == 5'(i + 1)) shift_d[i] = vote;
                    end
                end
                if (bit_count == BIT_AFTER_DATA) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (vote_pt) begin
                    par_mis_d = vote ^ (^shift_q) ^ par_typ_q;
                end
                if (bit_count == BIT_AFTER_PAR) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at the vote point so a back-to-back start bit is not missed.
                if (vote_pt) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    if (!vote) begin
                        serr_d = 1'b1;
                        perr_d = par_mis_q;
                    end else if (par_mis_q) begin
                        perr_d = 1'b1;
                    end else begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase

        if (state_q != S_IDLE && bit_count > last_idx) begin
            state_d  = S_IDLE;
            en_d     = 1'b0;
            p_data_d = p_data_q;
            dv_d     = 1'b0;
            perr_d   = 1'b0;
            serr_d   = 1'b0;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            smp_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            smp_q     <= smp_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_mis_q <= par_mis_d;
        end
    end

    assign edge_bit_enable = en_q;
    assign P_DATA          = p_data_q;
    assign data_valid      = dv_q;
    assign parity_error    = perr_q;
    assign stop_error      = serr_q;
    assign busy            = busy_q;

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Frame controller for the UART receive path. It sits directly downstream of the edge/bit counter and consumes its edge_count and bit_count. It detects the start bit and runs the counter through one frame. It majority-samples RX_IN mid-bit, deserialises the data bits LSB-first, and checks parity and the stop bit. It then delivers the byte with a one-cycle data_valid pulse, or flags the error.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE, 8, oversampling edges per bit. Must be even and at least 8. The counter's edge_count runs 0..PRESCALE-1. M = PRESCALE/2.

Ports:
clk_based_on_prescale  input  1  oversampling clock; all logic on its rising edge.
asy_reset  input  1  asynchronous, active-low reset.
RX_IN  input  1  serial line; idle high.
PAR_EN  input  1  parity bit present; latched at start detect.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; latched at start detect.
edge_count  input  4  edge index within the current bit, from the counter.
bit_count  input  5  frame bit index from the counter: 0 = start, 1..DATA_WIDTH = data, then parity if enabled, then stop.
edge_bit_enable  output  1  level output. High keeps the counter running. Low holds the counter cleared.
P_DATA  output  DATA_WIDTH  last good received word.
data_valid  output  1  one-cycle pulse when P_DATA is updated.
parity_error  output  1  one-cycle pulse on a parity mismatch.
stop_error  output  1  one-cycle pulse on a stop bit sampled as 0.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asy_reset=0, any time including mid-frame):
  - State goes to IDLE.
  - edge_bit_enable, P_DATA, data_valid, parity_error, stop_error and busy all go to 0.
  - Shift register and sample registers are cleared.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Sampler:
  - RX_IN is registered at edge_count = M-1, M and M+1.
  - The 2-of-3 majority vote is evaluated in the cycle where edge_count = M+2 ("vote point").
  - Example: PRESCALE=8 samples at edges 3, 4 and 5; vote point is edge 6.
- IDLE:
  - If RX_IN=0 on a clock edge, latch PAR_EN and PAR_TYP, go to START, and set edge_bit_enable=1 on that same edge.
  - The counter therefore presents edge_count=0, bit_count=0 on the next cycle.
- START:
  - Vote = 1 at the vote point is a glitch: go to IDLE and clear edge_bit_enable. No error pulse.
  - Vote = 0: stay in START until bit_count = 1, then go to DATA.
- DATA:
  - At each vote point, write the vote into shift bit (bit_count-1), LSB first.
  - When bit_count reaches DATA_WIDTH+1, go to PARITY if PAR_EN is latched, else go to STOP.
- PARITY:
  - Expected parity = XOR of all data bits XOR PAR_TYP.
  - At the vote point, record the mismatch internally (vote ≠ expected).
  - Go to STOP when bit_count advances.
- STOP, at the vote point, on the next clock edge:
  - If vote=1 and there is no parity mismatch: P_DATA <= shift register and data_valid=1 for one cycle.
  - If vote=1 and there is a parity mismatch: parity_error=1 for one cycle. P_DATA is unchanged and there is no data_valid.
  - If vote=0: stop_error=1 for one cycle. P_DATA is unchanged and there is no data_valid. This takes priority: if a parity mismatch also exists, both parity_error and stop_error pulse.
  - In all three cases the state goes to IDLE and edge_bit_enable goes to 0 on the same edge.
- Early stop exit: STOP is left before the stop bit ends, so the next start bit is caught even with zero idle time between frames.
- Back-to-back frames: RX_IN=0 on the first cycle back in IDLE starts a new frame immediately.
- Defensive exit: if bit_count exceeds the last frame index in any non-IDLE state, go to IDLE with no pulses.
- Stable inputs: PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
- RX_IN transitions between sample edges do not affect the vote.

Test Plan:
1. Frame 0xA5, PAR_EN=0, stop=1 → exactly one data_valid pulse, P_DATA=0xA5, no error pulses, busy falls on the same edge.
2. Frame 0x3C, PAR_EN=1, PAR_TYP=0, parity bit=0 → data_valid, P_DATA=0x3C. Repeat with parity bit=1 → parity_error pulse, no data_valid, P_DATA stays 0x3C.
3. Frame 0x01, PAR_EN=1, PAR_TYP=1, parity bit=0 → data_valid, P_DATA=0x01. Repeat with parity bit=1 → parity_error.
4. RX_IN low for 2 clocks, then high → START entered, return to IDLE at edge 6 of bit 0. edge_bit_enable drops, no pulses.
5. Frame 0x55 with stop bit=0 → stop_error pulse, no data_valid, P_DATA holds its previous value.
6. Two frames, 0x81 then 0x7E, with zero idle time → two data_valid pulses with the correct values. Then assert asy_reset during data bit 4 of a third frame → all outputs return to 0 and state to IDLE, and a following frame 0xC3 is received correctly.
